enc_8b10b: RTL and testbench
============================

# enc_8b10b

Single-lane 8b/10b encoder with running-disparity tracking, sitting directly upstream of the lane serializer. Takes one byte plus a control flag per cycle from the lane controller and produces one registered 10-bit symbol per cycle. The symbol goes straight onto the serializer's symbol input, so bit 0 is the first bit on the wire. Runs entirely in the lane controller's `clk_i` domain.

## Interface
Parameters: none. The width is fixed by the 8b/10b code.

Ports:
- `clk_i`  in  1  lane core clock; one clock only.
- `rst_i`  in  1  reset; synchronous, active-high.
- `data_i`  in  8  byte to encode. Bits [4:0] = EDCBA (A = bit 0); bits [7:5] = HGF.
- `k_i`  in  1  1 = encode as control symbol K.x.y; 0 = data symbol D.x.y.
- `valid_i`  in  1  `data_i`/`k_i` are valid this cycle. There is no backpressure.
- `symbol_o`  out  10  encoded symbol. Bit order from bit 0 to bit 9 is a,b,c,d,e,i,f,g,h,j (abcdei = 6b sub-block, fghj = 4b sub-block).
- `symbol_valid_o`  out  1  `symbol_o` is valid; connects to the serializer `symbol_valid_i`.
- `rd_o`  out  1  running disparity after the last emitted symbol: 0 = RD−, 1 = RD+.
- `code_err_o`  out  1  the symbol now on `symbol_o` came from an illegal K request.

## Operation
- **Encoding.** Standard 5b/6b and 3b/4b tables (IBM/PCIe Gen1/2).
  - The 6b sub-block is selected with the entering RD.
  - The 4b sub-block is selected with the RD after the 6b sub-block.
- **Disparity update.** RD after each sub-block flips if the sub-block is unbalanced (4 or 2 ones of 6; 3 or 1 ones of 4) and is kept if it is balanced. 000111 and 111000 count as balanced.
- **D.x.7 alternate.** D.x.7 uses the alternate encoding A7 (RD− 0111, RD+ 1000) when:
  - RD− and x ∈ {17,18,20}, or
  - RD+ and x ∈ {11,13,14}.
  
  Otherwise it uses the primary encoding P7 (RD− 1110, RD+ 0001). K.x.7 always uses A7.
- **Legal K codes:** K28.0–K28.7, K23.7, K27.7, K29.7, K30.7. K28.y uses 6b 001111 (RD−) / 110000 (RD+).
- **Illegal K** (`k_i`=1 with any other byte):
  - Encode as the data symbol D.x.y.
  - Assert `code_err_o` with that symbol.
  - RD updates normally.
- **`valid_i` = 0:** no symbol is produced.
  - `symbol_o` holds its last value.
  - `rd_o` is unchanged.
  - `symbol_valid_o` = 0 and `code_err_o` = 0 on the next cycle.
- **State:** a single RD flop plus the output registers. No FSM beyond RD±.

## Timing
- Latency is 1 cycle. Inputs sampled at edge N appear on `symbol_o`/`symbol_valid_o`/`code_err_o`/`rd_o` after edge N.
- Throughput is one symbol per cycle with back-to-back `valid_i`. The RD used for symbol N+1 is the RD produced by symbol N in the same cycle, with no bubble.
- Reset values: `symbol_o` = 10'h000, `symbol_valid_o` = 0, `rd_o` = 0 (RD−), `code_err_o` = 0.
- Reset asserted mid-stream:
  - The next cycle shows the reset values.
  - `valid_i` is ignored while `rst_i` = 1.
  - The first symbol after reset is encoded from RD−.
- No registered output is driven combinationally from the inputs.

## Test plan
- **Reset then K28.5.** Release reset; `k_i`=1, `data_i`=8'hBC, `valid_i`=1 for one cycle -> the next cycle shows `symbol_o`=10'h17C, `symbol_valid_o`=1, `rd_o`=1. A second K28.5 -> 10'h283, `rd_o`=0.
- **Balanced data.** Starting at RD−, D21.5 (8'hB5) three times back-to-back -> 10'h155 on each cycle, `rd_o` stays 0, `symbol_valid_o` high for three consecutive cycles.
- **D0.0 from RD−.** 8'h00 with `k_i`=0 -> 10'h0B9, `rd_o`=0 (the 6b sub-block flips RD, the 4b sub-block flips it back).
- **Alternate A7.** From RD−, D17.7 (8'hF1) -> 10'h3B1 (abcdei 100011, fghj 0111), `rd_o`=1. Then D11.7 (8'hEB) at RD+ -> the fghj bits equal 1000.
- **Illegal K.** `k_i`=1, `data_i`=8'h00 -> `symbol_o`=10'h0B9, `code_err_o`=1 for exactly one cycle, `rd_o` per the D0.0 rule. A following legal K28.5 -> `code_err_o`=0.
- **Gaps and reset.**
  - `valid_i` low for 3 cycles -> `symbol_valid_o`=0 and `symbol_o`/`rd_o` held.
  - Assert `rst_i` while `rd_o`=1 and `valid_i`=1 -> the next cycle shows all reset values.
  - The first K28.5 after reset -> 10'h17C.

Source files
------------

// File: rtl/enc_8b10b.sv
// Single-lane 8b/10b encoder with running-disparity tracking.
// One registered 10-bit symbol per valid input byte, 1-cycle latency, bit 0 = first on wire.
module enc_8b10b (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] data_i,
    input  logic       k_i,
    input  logic       valid_i,
    output logic [9:0] symbol_o,
    output logic       symbol_valid_o,
    output logic       rd_o,
    output logic       code_err_o
);

    localparam int unsigned SYM_W = 10;
    localparam int unsigned X_W   = 5;
    localparam int unsigned Y_W   = 3;
    localparam int unsigned C6_W  = 6;
    localparam int unsigned C4_W  = 4;

    // 5b/6b code as seen from RD-, packed {a,b,c,d,e,i} with a in the MSB
    function automatic logic [C6_W-1:0] f_6b_neg(input logic [X_W-1:0] x);
        logic [C6_W-1:0] c;
        c = 6'b000000;
        case (x)
            5'd0:  c = 6'b100111;
            5'd1:  c = 6'b011101;
            5'd2:  c = 6'b101101;
            5'd3:  c = 6'b110001;
            5'd4:  c = 6'b110101;
            5'd5:  c = 6'b101001;
            5'd6:  c = 6'b011001;
            5'd7:  c = 6'b111000;
            5'd8:  c = 6'b111001;
            5'd9:  c = 6'b100101;
            5'd10: c = 6'b010101;
            5'd11: c = 6'b110100;
            5'd12: c = 6'b001101;
            5'd13: c = 6'b101100;
            5'd14: c = 6'b011100;
            5'd15: c = 6'b010111;
            5'd16: c = 6'b011011;
            5'd17: c = 6'b100011;
            5'd18: c = 6'b010011;
            5'd19: c = 6'b110010;
            5'd20: c = 6'b001011;
            5'd21: c = 6'b101010;
            5'd22: c = 6'b011010;
            5'd23: c = 6'b111010;
            5'd24: c = 6'b110011;
            5'd25: c = 6'b100110;
            5'd26: c = 6'b010110;
            5'd27: c = 6'b110110;
            5'd28: c = 6'b001110;
            5'd29: c = 6'b101110;
            5'd30: c = 6'b011110;
            5'd31: c = 6'b101011;
            default: c = 6'b000000;
        endcase
        return c;
    endfunction

    // 3b/4b data code as seen from RD-, packed {f,g,h,j}; y=7 here is the primary P7
    function automatic logic [C4_W-1:0] f_4b_data_neg(input logic [Y_W-1:0] y);
        logic [C4_W-1:0] c;
        c = 4'b0000;
        case (y)
            3'd0: c = 4'b1011;
            3'd1: c = 4'b1001;
            3'd2: c = 4'b0101;
            3'd3: c = 4'b1100;
            3'd4: c = 4'b1101;
            3'd5: c = 4'b1010;
            3'd6: c = 4'b0110;
            3'd7: c = 4'b1110;
            default: c = 4'b0000;
        endcase
        return c;
    endfunction

    // K28.y 4b code with RD- entering the 4b sub-block; balanced y are inverted vs data
    function automatic logic [C4_W-1:0] f_4b_k28_neg(input logic [Y_W-1:0] y);
        logic [C4_W-1:0] c;
        c = 4'b0000;
        case (y)
            3'd0: c = 4'b1011;
            3'd1: c = 4'b0110;
            3'd2: c = 4'b1010;
            3'd3: c = 4'b1100;
            3'd4: c = 4'b1101;
            3'd5: c = 4'b0101;
            3'd6: c = 4'b1001;
            3'd7: c = 4'b0111;
            default: c = 4'b0000;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] f_ones6(input logic [C6_W-1:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]) + 3'(v[4]) + 3'(v[5]);
    endfunction

    function automatic logic [2:0] f_ones4(input logic [C4_W-1:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    logic [X_W-1:0]   w_x;
    logic [Y_W-1:0]   w_y;
    logic             w_k_legal;
    logic             w_k28;
    logic [C6_W-1:0]  w_6b_neg;
    logic             w_6b_unbal;
    logic [C6_W-1:0]  w_6b;
    logic             w_rd_mid;
    logic             w_use_a7;
    logic [C4_W-1:0]  w_4b_neg;
    logic             w_4b_unbal;
    logic [C4_W-1:0]  w_4b;
    logic             w_rd_next;
    logic [SYM_W-1:0] w_symbol;
    logic             w_code_err;

    logic [SYM_W-1:0] r_symbol;
    logic             r_symbol_valid;
    logic             r_rd;
    logic             r_code_err;

    // Next-symbol and next-RD computation from the current RD
    always_comb begin
        w_x        = data_i[4:0];
        w_y        = data_i[7:5];
        w_k_legal  = 1'b0;
        w_k28      = 1'b0;
        w_6b_neg   = 6'b000000;
        w_6b_unbal = 1'b0;
        w_6b       = 6'b000000;
        w_rd_mid   = r_rd;
        w_use_a7   = 1'b0;
        w_4b_neg   = 4'b0000;
        w_4b_unbal = 1'b0;
        w_4b       = 4'b0000;
        w_rd_next  = r_rd;
        w_symbol   = '0;
        w_code_err = 1'b0;

        w_k28     = k_i && (w_x == 5'd28);
        w_k_legal = w_k28 || (k_i && (w_y == 3'd7) &&
                    ((w_x == 5'd23) || (w_x == 5'd27) || (w_x == 5'd29) || (w_x == 5'd30)));
        w_code_err = k_i && !w_k_legal;

        w_6b_neg   = w_k28 ? 6'b001111 : f_6b_neg(w_x);
        w_6b_unbal = (f_ones6(w_6b_neg) != 3'd3);
        // D.7 is balanced but still has distinct RD+/RD- forms
        w_6b       = (r_rd && (w_6b_unbal || (!w_k28 && w_x == 5'd7))) ? ~w_6b_neg : w_6b_neg;
        w_rd_mid   = r_rd ^ w_6b_unbal;

        w_use_a7 = (w_y == 3'd7) && (w_k_legal ||
                   (!w_rd_mid && ((w_x == 5'd17) || (w_x == 5'd18) || (w_x == 5'd20))) ||
                   ( w_rd_mid && ((w_x == 5'd11) || (w_x == 5'd13) || (w_x == 5'd14))));

        if (w_k28) begin
            w_4b_neg = f_4b_k28_neg(w_y);
        end else if (w_use_a7) begin
            w_4b_neg = 4'b0111;
        end else begin
            w_4b_neg = f_4b_data_neg(w_y);
        end
        w_4b_unbal = (f_ones4(w_4b_neg) != 3'd2);
        w_4b       = (w_rd_mid && (w_4b_unbal || w_k28 || (w_y == 3'd3))) ? ~w_4b_neg : w_4b_neg;
        w_rd_next  = w_rd_mid ^ w_4b_unbal;

        w_symbol = {w_4b[0], w_4b[1], w_4b[2], w_4b[3],
                    w_6b[0], w_6b[1], w_6b[2], w_6b[3], w_6b[4], w_6b[5]};
    end

    // Output registers and running-disparity flop
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_symbol       <= '0;
            r_symbol_valid <= 1'b0;
            r_rd           <= 1'b0;
            r_code_err     <= 1'b0;
        end else if (valid_i) begin
            r_symbol       <= w_symbol;
            r_symbol_valid <= 1'b1;
            r_rd           <= w_rd_next;
            r_code_err     <= w_code_err;
        end else begin
            r_symbol_valid <= 1'b0;
            r_code_err     <= 1'b0;
        end
    end

    assign symbol_o       = r_symbol;
    assign symbol_valid_o = r_symbol_valid;
    assign rd_o           = r_rd;
    assign code_err_o     = r_code_err;

endmodule

// File: tb/tb_enc_8b10b.sv
// Self-checking bench for enc_8b10b: table-driven reference model checked every cycle,
// plus hand-computed literal symbols for the directed scenarios.
module tb_enc_8b10b;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] data_i = 8'h00;
    logic       k_i = 1'b0;
    logic       valid_i = 1'b0;
    logic [9:0] symbol_o;
    logic       symbol_valid_o;
    logic       rd_o;
    logic       code_err_o;

    int n_total = 0;
    int n_pass  = 0;
    logic chk_en = 1'b0;

    enc_8b10b dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .data_i         (data_i),
        .k_i            (k_i),
        .valid_i        (valid_i),
        .symbol_o       (symbol_o),
        .symbol_valid_o (symbol_valid_o),
        .rd_o           (rd_o),
        .code_err_o     (code_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Standard code tables, both disparity columns written out; codes are {a..i} / {f..j}, first bit in MSB
    logic [5:0] t6n [0:31] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    logic [5:0] t6p [0:31] = '{
        6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
        6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
        6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
        6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
    logic [3:0] t4n [0:7] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
    logic [3:0] t4p [0:7] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
    logic [3:0] k4n [0:7] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
    logic [3:0] k4p [0:7] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};

    function automatic void model_enc(input logic [7:0] d, input logic k, input logic rd,
                                      output logic [9:0] sym, output logic rd_out, output logic err);
        int x, y;
        logic legal, k28, rd1;
        logic [5:0] c6;
        logic [3:0] c4;
        x = int'(d[4:0]);
        y = int'(d[7:5]);
        k28   = k && (x == 28);
        legal = k28 || (k && y == 7 && (x == 23 || x == 27 || x == 29 || x == 30));
        err   = k && !legal;
        if (k28) c6 = rd ? 6'b110000 : 6'b001111;
        else     c6 = rd ? t6p[x] : t6n[x];
        rd1 = ($countones(c6) == 3) ? rd : ~rd;
        if (k28)
            c4 = rd1 ? k4p[y] : k4n[y];
        else if (y == 7 && (legal || (!rd1 && (x == 17 || x == 18 || x == 20)) ||
                                     (rd1 && (x == 11 || x == 13 || x == 14))))
            c4 = rd1 ? 4'b1000 : 4'b0111;
        else
            c4 = rd1 ? t4p[y] : t4n[y];
        rd_out = ($countones(c4) == 2) ? rd1 : ~rd1;
        sym = '0;
        for (int i = 0; i < 6; i++) sym[i] = c6[5-i];
        for (int i = 0; i < 4; i++) sym[6+i] = c4[3-i];
    endfunction

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model state, advanced on the same edge as the DUT
    logic [9:0] m_sym   = '0;
    logic       m_valid = 1'b0;
    logic       m_rd    = 1'b0;
    logic       m_err   = 1'b0;
    logic [9:0] mt_sym;
    logic       mt_rd, mt_err;

    always @(posedge clk_i) begin
        if (rst_i) begin
            m_sym <= '0; m_valid <= 1'b0; m_rd <= 1'b0; m_err <= 1'b0;
        end else if (valid_i) begin
            model_enc(data_i, k_i, m_rd, mt_sym, mt_rd, mt_err);
            m_sym <= mt_sym; m_valid <= 1'b1; m_rd <= mt_rd; m_err <= mt_err;
        end else begin
            m_valid <= 1'b0; m_err <= 1'b0;
        end
    end

    always @(negedge clk_i) begin
        if (chk_en) begin
            chk("model_symbol", symbol_o, m_sym);
            chk("model_valid", 10'(symbol_valid_o), 10'(m_valid));
            chk("model_rd", 10'(rd_o), 10'(m_rd));
            chk("model_err", 10'(code_err_o), 10'(m_err));
        end
    end

    // Apply inputs, then land 1 time unit after the edge that registers them
    task automatic step(input logic v, input logic k, input logic [7:0] d);
        valid_i = v; k_i = k; data_i = d;
        @(posedge clk_i); #1;
    endtask

    initial begin
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        chk_en = 1'b1;
        chk("rst_symbol", symbol_o, 10'h000);
        chk("rst_valid", 10'(symbol_valid_o), 10'd0);
        chk("rst_rd", 10'(rd_o), 10'd0);
        chk("rst_err", 10'(code_err_o), 10'd0);
        rst_i = 1'b0;

        step(1'b1, 1'b1, 8'hBC);
        chk("k28_5_neg", symbol_o, 10'h17C);
        chk("k28_5_neg_valid", 10'(symbol_valid_o), 10'd1);
        chk("k28_5_neg_rd", 10'(rd_o), 10'd1);
        step(1'b1, 1'b1, 8'hBC);
        chk("k28_5_pos", symbol_o, 10'h283);
        chk("k28_5_pos_rd", 10'(rd_o), 10'd0);

        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 8'hB5);
            chk("d21_5", symbol_o, 10'h155);
            chk("d21_5_rd", 10'(rd_o), 10'd0);
            chk("d21_5_valid", 10'(symbol_valid_o), 10'd1);
        end

        step(1'b1, 1'b0, 8'h00);
        chk("d0_0", symbol_o, 10'h0B9);
        chk("d0_0_rd", 10'(rd_o), 10'd0);

        step(1'b1, 1'b0, 8'hF1);
        chk("d17_7_a7", symbol_o, 10'h3B1);
        chk("d17_7_rd", 10'(rd_o), 10'd1);
        step(1'b1, 1'b0, 8'hEB);
        chk("d11_7_fghj", 10'(symbol_o[9:6]), 10'(4'b0001));
        chk("d11_7", symbol_o, 10'h04B);
        chk("d11_7_rd", 10'(rd_o), 10'd0);

        step(1'b1, 1'b1, 8'h00);
        chk("illegal_k_sym", symbol_o, 10'h0B9);
        chk("illegal_k_err", 10'(code_err_o), 10'd1);
        chk("illegal_k_rd", 10'(rd_o), 10'd0);
        step(1'b1, 1'b1, 8'hBC);
        chk("legal_k_err", 10'(code_err_o), 10'd0);
        chk("legal_k_sym", symbol_o, 10'h17C);

        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'h00);
            chk("gap_valid", 10'(symbol_valid_o), 10'd0);
            chk("gap_hold_sym", symbol_o, 10'h17C);
            chk("gap_hold_rd", 10'(rd_o), 10'd1);
            chk("gap_err", 10'(code_err_o), 10'd0);
        end

        rst_i = 1'b1;
        step(1'b1, 1'b1, 8'h00);
        chk("midrst_symbol", symbol_o, 10'h000);
        chk("midrst_valid", 10'(symbol_valid_o), 10'd0);
        chk("midrst_rd", 10'(rd_o), 10'd0);
        chk("midrst_err", 10'(code_err_o), 10'd0);
        rst_i = 1'b0;
        step(1'b1, 1'b1, 8'hBC);
        chk("post_rst_k28_5", symbol_o, 10'h17C);

        // Every data byte back-to-back, then every byte as a K request with random gaps
        for (int b = 0; b < 256; b++) step(1'b1, 1'b0, 8'(b));
        for (int b = 0; b < 256; b++) step(1'($urandom_range(0, 3) != 0), 1'b1, 8'(b));
        for (int b = 0; b < 64; b++)  step(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
